// File: rtl/pipe_stage_reg.sv
// -----------------------------------------------------------------------------
// pipe_stage_reg
//
// Generic parametrised pipeline latch carrying a control field and a data
// field through DEPTH chained stages. A bubble always has valid=0 and ctrl=0,
// so it behaves as a NOP downstream. The data field is never cleared by a
// flush; only reset clears it.
//
// Ports
//   CLK         rising-edge clock
//   RST         synchronous active-high reset (overrides everything)
//   enable      advance all stages this cycle (0 = stall/hold)
//   flush       per-stage bubble request, bit 0 = stage nearest the input
//   valid_in    incoming instruction is real
//   ctrl_in     incoming control field
//   data_in     incoming data field
//   valid_out   last stage holds a real instruction
//   ctrl_out    last-stage control field
//   data_out    last-stage data field
//   occupancy   registered count of stages holding a valid instruction
//   cnt_clr     synchronous clear of both performance counters
//   stall_cnt   saturating count of stalled edges with a non-empty pipe
//   bubble_cnt  saturating count of enabled edges retiring a bubble
// -----------------------------------------------------------------------------
module pipe_stage_reg #(
   parameter int CTRL_W = 16,
   parameter int DATA_W = 128,
   parameter int DEPTH  = 1,
   parameter int CNT_W  = 16
) (
   input  logic                       CLK,
   input  logic                       RST,
   input  logic                       enable,
   input  logic [DEPTH-1:0]           flush,
   input  logic                       valid_in,
   input  logic [CTRL_W-1:0]          ctrl_in,
   input  logic [DATA_W-1:0]          data_in,
   output logic                       valid_out,
   output logic [CTRL_W-1:0]          ctrl_out,
   output logic [DATA_W-1:0]          data_out,
   output logic [$clog2(DEPTH+1)-1:0] occupancy,
   input  logic                       cnt_clr,
   output logic [CNT_W-1:0]           stall_cnt,
   output logic [CNT_W-1:0]           bubble_cnt
);

   localparam int               OCC_W   = $clog2(DEPTH+1);
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

   // Number of set bits in a valid vector.
   function automatic logic [OCC_W-1:0] popCount(input logic [DEPTH-1:0] bits);
      logic [OCC_W-1:0] sum;
      sum = {OCC_W{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
         sum = sum + OCC_W'(bits[i]);
      end
      return sum;
   endfunction

   // Increment that sticks at the all-ones value.
   function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] value);
      logic [CNT_W-1:0] result;
      if (value == CNT_MAX) begin
         result = value;
      end else begin
         result = value + CNT_W'(1);
      end
      return result;
   endfunction

   // Stage registers
   logic [DEPTH-1:0]  validR;
   logic [CTRL_W-1:0] ctrlR [DEPTH];
   logic [DATA_W-1:0] dataR [DEPTH];
   logic [OCC_W-1:0]  occR;
   logic [CNT_W-1:0]  stallCntR;
   logic [CNT_W-1:0]  bubbleCntR;

   // Per-stage source (what stage i would load when enabled)
   logic [DEPTH-1:0]  srcValid;
   logic [CTRL_W-1:0] srcCtrl [DEPTH];
   logic [DATA_W-1:0] srcData [DEPTH];

   // Next-state values for every stage
   logic [DEPTH-1:0]  nextValid;
   logic [CTRL_W-1:0] nextCtrl [DEPTH];
   logic [DATA_W-1:0] nextData [DEPTH];

   // Source selection: stage 0 takes the pipeline input, stage i takes stage i-1.
   always_comb begin
      srcValid   = validR;
      srcValid[0] = valid_in;
      srcCtrl[0] = ctrl_in;
      srcData[0] = data_in;
      for (int i = 1; i < DEPTH; i++) begin
         srcValid[i] = validR[i-1];
         srcCtrl[i]  = ctrlR[i-1];
         srcData[i]  = dataR[i-1];
      end
   end

   // Next-state: flush beats enable beats hold. Flush only squashes the
   // instruction entering a stage; the sources above are pre-edge values, so
   // the instruction leaving a flushed stage still moves on.
   always_comb begin
      nextValid = validR;
      for (int i = 0; i < DEPTH; i++) begin
         nextCtrl[i] = ctrlR[i];
         nextData[i] = dataR[i];
         if (flush[i]) begin
            nextValid[i] = 1'b0;
            nextCtrl[i]  = {CTRL_W{1'b0}};
            nextData[i]  = dataR[i];
         end else if (enable) begin
            nextValid[i] = srcValid[i];
            nextCtrl[i]  = srcValid[i] ? srcCtrl[i] : {CTRL_W{1'b0}};
            nextData[i]  = srcData[i];
         end else begin
            nextValid[i] = validR[i];
            nextCtrl[i]  = ctrlR[i];
            nextData[i]  = dataR[i];
         end
      end
   end

   // Stage register update.
   always_ff @(posedge CLK) begin
      if (RST) begin
         validR <= {DEPTH{1'b0}};
         for (int i = 0; i < DEPTH; i++) begin
            ctrlR[i] <= {CTRL_W{1'b0}};
            dataR[i] <= {DATA_W{1'b0}};
         end
      end else begin
         validR <= nextValid;
         for (int i = 0; i < DEPTH; i++) begin
            ctrlR[i] <= nextCtrl[i];
            dataR[i] <= nextData[i];
         end
      end
   end

   // Occupancy tracks the valid bits on the same edge they are written.
   always_ff @(posedge CLK) begin
      if (RST) begin
         occR <= {OCC_W{1'b0}};
      end else begin
         occR <= popCount(nextValid);
      end
   end

   // Performance counters, evaluated on pre-edge occupancy and valid_out.
   always_ff @(posedge CLK) begin
      if (RST) begin
         stallCntR  <= CNT_ZERO;
         bubbleCntR <= CNT_ZERO;
      end else if (cnt_clr) begin
         stallCntR  <= CNT_ZERO;
         bubbleCntR <= CNT_ZERO;
      end else begin
         if (!enable && (occR != {OCC_W{1'b0}})) begin
            stallCntR <= satInc(stallCntR);
         end else begin
            stallCntR <= stallCntR;
         end
         if (enable && !validR[DEPTH-1]) begin
            bubbleCntR <= satInc(bubbleCntR);
         end else begin
            bubbleCntR <= bubbleCntR;
         end
      end
   end

   // Outputs are driven straight from registers.
   assign valid_out  = validR[DEPTH-1];
   assign ctrl_out   = ctrlR[DEPTH-1];
   assign data_out   = dataR[DEPTH-1];
   assign occupancy  = occR;
   assign stall_cnt  = stallCntR;
   assign bubble_cnt = bubbleCntR;

endmodule
